// File: rtl/cmp_relation_tracker.sv
// Debounces the 4-bit comparator's g/e/l flags into a committed relation and
// reports stable crossings as one-cycle events, a saturating count and a sticky error.
//
// state   | meaning
// --------+-----------------------------------------------
// UNKNOWN | no relation committed since reset or clr
// LESS    | data1 < data2 held for STABLE_CNT legal samples
// EQUAL   | data1 == data2 held for STABLE_CNT legal samples
// GREATER | data1 > data2 held for STABLE_CNT legal samples
module cmp_relation_tracker #(
  parameter int STABLE_CNT = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             g,
  input  logic             e,
  input  logic             l,
  input  logic             clr,
  output logic [1:0]       state,
  output logic             rise_evt,
  output logic             fall_evt,
  output logic [CNT_W-1:0] cross_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    S_UNKNOWN = 2'b00,
    S_LESS    = 2'b01,
    S_EQUAL   = 2'b10,
    S_GREATER = 2'b11
  } rel_t;

  localparam logic [3:0]       RUN_MAX = 4'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rel_t       cur;
  rel_t       cand;
  rel_t       rel_s;
  rel_t       cand_nxt;
  logic [3:0] run;
  logic [3:0] run_nxt;
  logic       onehot;
  logic       legal;
  logic       illegal;
  logic       commit;
  logic       rise_nxt;
  logic       fall_nxt;

  always_comb begin
    rel_s  = S_UNKNOWN;
    onehot = 1'b0;
    case ({g, e, l})
      3'b100:  begin rel_s = S_GREATER; onehot = 1'b1; end
      3'b010:  begin rel_s = S_EQUAL;   onehot = 1'b1; end
      3'b001:  begin rel_s = S_LESS;    onehot = 1'b1; end
      default: begin rel_s = S_UNKNOWN; onehot = 1'b0; end
    endcase
    legal   = in_valid & onehot;
    illegal = in_valid & ~onehot;

    cand_nxt = cand;
    run_nxt  = run;
    if (legal) begin
      if (rel_s == cand) begin
        run_nxt = (run >= RUN_MAX) ? RUN_MAX : run + 4'd1;
      end else begin
        cand_nxt = rel_s;
        run_nxt  = 4'd1;
      end
    end

    commit = legal && (run_nxt == RUN_MAX) && (cand_nxt != cur);
    // A commit always changes state, so "from LESS or EQUAL" into GREATER
    // reduces to "not from UNKNOWN"; likewise for LESS.
    rise_nxt = commit && (cand_nxt == S_GREATER) && (cur != S_UNKNOWN);
    fall_nxt = commit && (cand_nxt == S_LESS)    && (cur != S_UNKNOWN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= S_UNKNOWN;
      cand      <= S_UNKNOWN;
      run       <= 4'd0;
      rise_evt  <= 1'b0;
      fall_evt  <= 1'b0;
      cross_cnt <= '0;
      err       <= 1'b0;
    end else begin
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
      if (clr) begin
        cur       <= S_UNKNOWN;
        cand      <= S_UNKNOWN;
        run       <= 4'd0;
        cross_cnt <= '0;
        err       <= 1'b0;
      end else if (illegal) begin
        err  <= 1'b1;
        cand <= S_UNKNOWN;
        run  <= 4'd0;
      end else if (legal) begin
        cand <= cand_nxt;
        run  <= run_nxt;
        if (commit) begin
          cur      <= cand_nxt;
          rise_evt <= rise_nxt;
          fall_evt <= fall_nxt;
          if ((rise_nxt || fall_nxt) && (cross_cnt != CNT_MAX)) begin
            cross_cnt <= cross_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_cmp_relation_tracker.sv
// Bench for cmp_relation_tracker: three parameterisations share one stimulus stream and
// are checked every cycle against a history-based model, plus directed literal checks.
module tb_cmp_relation_tracker;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic g = 1'b0, e = 1'b0, l = 1'b0;
  logic clr = 1'b0;

  logic [1:0] st0, st1, st2;
  logic       r0, r1, r2, f0, f1, f2, e0, e1, e2;
  logic [7:0] c0, c2;
  logic [1:0] c1;

  // instance 0: default, 1: narrow counter, 2: single-sample commit
  cmp_relation_tracker #(.STABLE_CNT(3), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .g(g), .e(e), .l(l), .clr(clr),
    .state(st0), .rise_evt(r0), .fall_evt(f0), .cross_cnt(c0), .err(e0));
  cmp_relation_tracker #(.STABLE_CNT(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .g(g), .e(e), .l(l), .clr(clr),
    .state(st1), .rise_evt(r1), .fall_evt(f1), .cross_cnt(c1), .err(e1));
  cmp_relation_tracker #(.STABLE_CNT(1), .CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .g(g), .e(e), .l(l), .clr(clr),
    .state(st2), .rise_evt(r2), .fall_evt(f2), .cross_cnt(c2), .err(e2));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sc_of(input int i);
    return (i == 2) ? 1 : 3;
  endfunction

  function automatic int cmax_of(input int i);
    return (i == 1) ? 3 : 255;
  endfunction

  // Model: relation codes 0 unknown, 1 less, 2 equal, 3 greater. The list of legal
  // samples since the last break (illegal/clr/reset) decides stability directly.
  int hist[$];
  int m_st[N];
  int m_cnt[N];
  bit m_rise[N];
  bit m_fall[N];
  bit m_err;

  function automatic int stable_rel(input int k);
    int sz;
    int r;
    sz = hist.size();
    if (sz < k) return 0;
    r = hist[sz-1];
    for (int j = 1; j < k; j++)
      if (hist[sz-1-j] != r) return 0;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      m_err = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_st[i] = 0; m_cnt[i] = 0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        m_rise[i] = 1'b0; m_fall[i] = 1'b0;
      end
      if (clr) begin
        hist.delete();
        m_err = 1'b0;
        for (int i = 0; i < N; i++) begin
          m_st[i] = 0; m_cnt[i] = 0;
        end
      end else if (in_valid) begin
        if (int'(g) + int'(e) + int'(l) == 1) begin
          hist.push_back(g ? 3 : (e ? 2 : 1));
          if (hist.size() > 16) void'(hist.pop_front());
          for (int i = 0; i < N; i++) begin
            int r;
            int old;
            r = stable_rel(sc_of(i));
            if (r != 0 && r != m_st[i]) begin
              old = m_st[i];
              m_st[i] = r;
              m_rise[i] = (r == 3) && (old == 1 || old == 2);
              m_fall[i] = (r == 1) && (old == 3 || old == 2);
              if ((m_rise[i] || m_fall[i]) && m_cnt[i] < cmax_of(i)) m_cnt[i]++;
            end
          end
        end else begin
          m_err = 1'b1;
          hist.delete();
        end
      end
    end
  end

  function automatic int d_st(input int i);
    return (i == 0) ? int'(st0) : (i == 1) ? int'(st1) : int'(st2);
  endfunction
  function automatic int d_rise(input int i);
    return (i == 0) ? int'(r0) : (i == 1) ? int'(r1) : int'(r2);
  endfunction
  function automatic int d_fall(input int i);
    return (i == 0) ? int'(f0) : (i == 1) ? int'(f1) : int'(f2);
  endfunction
  function automatic int d_cnt(input int i);
    return (i == 0) ? int'(c0) : (i == 1) ? int'(c1) : int'(c2);
  endfunction
  function automatic int d_err(input int i);
    return (i == 0) ? int'(e0) : (i == 1) ? int'(e1) : int'(e2);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("state[%0d]", i), d_st(i), m_st[i]);
        check($sformatf("rise[%0d]", i), d_rise(i), int'(m_rise[i]));
        check($sformatf("fall[%0d]", i), d_fall(i), int'(m_fall[i]));
        check($sformatf("cnt[%0d]", i), d_cnt(i), m_cnt[i]);
        check($sformatf("err[%0d]", i), d_err(i), int'(m_err));
      end
    end
  end

  localparam logic [2:0] LT = 3'b001, EQ = 3'b010, GT = 3'b100;

  // Drive one cycle's inputs and return at the following negedge.
  task automatic step(input logic v, input logic [2:0] gel, input logic c);
    in_valid = v;
    {g, e, l} = gel;
    clr = c;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 3'b000, 1'b0);
  endtask

  task automatic mid_reset();
    in_valid = 1'b0; {g, e, l} = 3'b000; clr = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", int'(st0), 0);
    check("async_rst_cnt", int'(c0), 0);
    check("async_rst_err", int'(e0), 0);
    check("async_rst_evt", int'(r0) + int'(f0), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset_state", int'(st0), 0);
    check("reset_cnt", int'(c0), 0);
    check("reset_err", int'(e0), 0);

    // commit into LESS from UNKNOWN
    step(1, LT, 0); check("less_edge1", int'(st0), 0);
    step(1, LT, 0); check("less_edge2", int'(st0), 0);
    step(1, LT, 0); check("less_edge3", int'(st0), 1);
    check("less_no_evt", int'(r0) + int'(f0), 0);
    step(1, LT, 0); step(1, LT, 0);
    check("less_cnt", int'(c0), 0);

    // LESS -> GREATER
    step(1, GT, 0); step(1, GT, 0);
    check("gt_pending", int'(st0), 1);
    step(1, GT, 0);
    check("gt_state", int'(st0), 3);
    check("gt_rise", int'(r0), 1);
    check("gt_cnt", int'(c0), 1);
    check("b_cnt1", int'(c1), 1);
    idle();
    check("gt_rise_once", int'(r0), 0);

    // GREATER -> LESS
    step(1, LT, 0); step(1, LT, 0); step(1, LT, 0);
    check("lt_fall", int'(f0), 1);
    check("lt_cnt", int'(c0), 2);
    check("b_cnt2", int'(c1), 2);
    check("c_state_lt", int'(st2), 1);

    step(1, GT, 0); step(1, GT, 0); step(1, GT, 0);
    check("b_cnt3", int'(c1), 3);

    // glitch while GREATER, with gaps
    step(1, GT, 0); idle(); step(1, GT, 0); step(1, LT, 0);
    step(1, GT, 0); idle(); step(1, GT, 0);
    check("glitch_state", int'(st0), 3);
    check("glitch_cnt", int'(c0), 3);

    // gaps do not break a run
    step(1, LT, 0); idle(); step(1, LT, 0); idle(); idle();
    check("gap_pending", int'(st0), 3);
    step(1, LT, 0);
    check("gap_commit", int'(st0), 1);
    check("gap_fall", int'(f0), 1);
    check("b_cnt4_sat", int'(c1), 3);

    // illegal sample restarts the run
    step(1, GT, 0);
    step(1, 3'b110, 0);
    check("illegal_err", int'(e0), 1);
    check("illegal_state", int'(st0), 1);
    step(1, GT, 0); step(1, GT, 0);
    check("illegal_restart", int'(st0), 1);
    step(1, GT, 0);
    check("illegal_commit", int'(st0), 3);
    check("illegal_cnt", int'(c0), 5);
    check("b_cnt5_sat", int'(c1), 3);
    idle(); idle();
    check("err_sticky", int'(e0), 1);

    // clr with a same-cycle sample
    step(1, LT, 1);
    check("clr_state", int'(st0), 0);
    check("clr_cnt", int'(c0), 0);
    check("clr_err", int'(e0), 0);
    check("clr_c_state", int'(st2), 0);
    step(1, LT, 0); step(1, LT, 0);
    check("clr_discard", int'(st0), 0);
    check("c_unknown_to_lt", int'(st2), 1);
    check("c_no_evt", int'(f2), 0);
    step(1, LT, 0);
    check("clr_recommit", int'(st0), 1);

    // asynchronous reset mid-run
    step(1, GT, 0); step(1, GT, 0);
    mid_reset();
    step(1, GT, 0); step(1, GT, 0);
    check("rst_restart", int'(st0), 0);
    step(1, GT, 0);
    check("rst_recommit", int'(st0), 3);
    check("rst_no_evt", int'(r0), 0);

    // randomized phase
    begin
      logic [2:0] cur_rel;
      logic [2:0] bad [5];
      bad[0] = 3'b000; bad[1] = 3'b110; bad[2] = 3'b101; bad[3] = 3'b011; bad[4] = 3'b111;
      cur_rel = EQ;
      for (int k = 0; k < 4000; k++) begin
        if ($urandom_range(0, 99) < 12) begin
          case ($urandom_range(0, 2))
            0: cur_rel = LT;
            1: cur_rel = EQ;
            default: cur_rel = GT;
          endcase
        end
        if ($urandom_range(0, 999) < 3) mid_reset();
        else if ($urandom_range(0, 99) < 4)
          step(1, bad[$urandom_range(0, 4)], 0);
        else
          step($urandom_range(0, 99) < 75, cur_rel, $urandom_range(0, 199) == 0);
      end
    end

    idle();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
